imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequencer and port owner for the 4096x16 single-port instruction memory.
- Holds the program counter and drives the memory address each cycle.
- Registers the fetched instruction into the IF stage; handles stall, branch redirect and halt.
- Shares the memory port with a program loader, which may write the memory only while the CPU is not running.

Parameters:
- AW, 12, instruction memory address width (PC width).
- DW, 16, instruction width.
- HALT_OP, 4'b1111, opcode in bits [15:12] that halts fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin fetching at start_pc (honoured in IDLE/HALT only).
- start_pc  in  AW  fetch start address.
- stall  in  1  hold PC and IF registers this cycle.
- br_taken  in  1  branch resolved taken this cycle.
- br_target  in  AW  branch target PC.
- ld_req  in  1  loader requests the memory port.
- ld_we  in  1  loader write strobe.
- ld_addr  in  AW  loader write address.
- ld_data  in  DW  loader write data.
- ld_gnt  out  1  loader owns the port.
- mem_addr  out  AW  instruction memory address.
- mem_we  out  1  instruction memory write enable.
- mem_wdata  out  DW  instruction memory write data.
- mem_rdata  in  DW  memory read data; combinational from mem_addr.
- IF_instruction  out  DW  registered fetched instruction.
- IF_pc  out  AW  PC of IF_instruction.
- IF_valid  out  1  IF_instruction is valid.
- halted  out  1  state == HALT.

Behaviour:
- States:
  - IDLE: reset state.
  - LOAD: loader owns the port.
  - RUN: fetching.
  - HALT: fetch stopped.
- Reset:
  - state = IDLE, pc = RESET_PC.
  - IF_instruction = 0, IF_pc = 0, IF_valid = 0, halted = 0.
  - Reset mid-LOAD or mid-RUN aborts the operation immediately; no write occurs in the reset cycle.
- IDLE/HALT transitions:
  - ld_req has priority and moves to LOAD.
  - Otherwise start moves to RUN with pc <= start_pc.
  - IF_valid = 0 in both states.
- LOAD:
  - ld_gnt = 1, mem_addr = ld_addr, mem_we = ld_we, mem_wdata = ld_data. These are combinational, giving 1 write per cycle.
  - Leaves to IDLE in the cycle after ld_req is seen low; start is ignored while in LOAD.
- In all states other than LOAD: ld_gnt = 0, mem_we = 0, mem_addr = pc, mem_wdata = 0.
- ld_req during RUN is not granted; the loader waits for HALT or IDLE.
- RUN, per cycle, in priority order:
  1. br_taken: pc <= br_target, IF_valid <= 0 (one-cycle flush). Overrides stall.
  2. stall: pc, IF_instruction, IF_pc and IF_valid all hold.
  3. else: IF_instruction <= mem_rdata, IF_pc <= pc, IF_valid <= 1, pc <= pc+1.
- Fetch latency: instruction visible on IF_* one cycle after its address appears on mem_addr.
- PC wraps from 4095 to 0 (mod 2^AW); no error is flagged.
- Halt:
  - A normal fetch whose mem_rdata[15:12] == HALT_OP is captured (IF_valid = 1 for that word) and state moves to HALT.
  - pc then points to the halt address + 1.
  - If br_taken and a halt word coincide, the branch wins and the halt word is discarded.
- halted is registered and equals (state == HALT).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch[15:0] (count of RUN cycles that capture an instruction) and perf_stall[15:0] (count of RUN cycles with stall high and br_taken low).
  - Both counters saturate at 16'hFFFF, clear on reset, and clear on start acceptance.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ld_req=1 with writes 0x6181@0, 0x6242@1, 0xF000@2, then ld_req=0 -> ld_gnt high during LOAD, mem_we follows ld_we; state returns to IDLE.
- start, start_pc=0, no stall -> IF_pc 0, 1, 2 on consecutive cycles, with IF_instruction 0x6181, 0x6242, 0xF000; halted=1 the cycle after 0xF000 is captured, then IF_valid=0.
- RUN with stall high for 3 cycles at pc=5 -> IF_* unchanged for 3 cycles, mem_addr=5 throughout, then resumes at IF_pc=5.
- br_taken=1, br_target=0x100, with stall=1 in the same cycle -> next cycle IF_valid=0, mem_addr=0x100; the following cycle IF_pc=0x100.
- start_pc=0xFFF with memory holding non-halt words -> IF_pc sequence 0xFFF, 0x000, 0x001.
- ld_req asserted during RUN -> ld_gnt stays 0 and mem_we stays 0 until HALT, then LOAD is entered. Reset asserted mid-LOAD with ld_we=1 -> no write that cycle, state IDLE.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port owner: PC sequencing, IF-stage register, stall/branch/halt, loader arbitration.
// Optional perf counters (perf_fetch, perf_stall) are built when FETCH_PERF_CNT_EN is defined.
module imem_fetch_ctrl #(
  parameter int            AW       = 12,
  parameter int            DW       = 16,
  parameter logic [3:0]    HALT_OP  = 4'b1111,
  parameter int            RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] IF_instruction,
  output logic [AW-1:0] IF_pc,
  output logic          IF_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]   perf_fetch,
  output logic [15:0]   perf_stall,
`endif
  output logic          halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] pc;
  logic          idle_like, start_ok, fetch, is_halt;

  assign idle_like = (state == S_IDLE) || (state == S_HALT);
  assign start_ok  = idle_like && !ld_req && start;
  assign fetch     = (state == S_RUN) && !br_taken && !stall;
  assign is_halt   = (mem_rdata[DW-1:DW-4] == HALT_OP);

  // Loader signals pass straight through so it gets one write per cycle; a write is suppressed in a reset cycle.
  always_comb begin
    ld_gnt    = (state == S_LOAD);
    mem_addr  = ld_gnt ? ld_addr : pc;
    mem_we    = ld_gnt && ld_we && !reset;
    mem_wdata = ld_gnt ? ld_data : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: begin
        if (ld_req)     state_nxt = S_LOAD;
        else if (start) state_nxt = S_RUN;
      end
      S_LOAD:  if (!ld_req) state_nxt = S_IDLE;
      S_RUN:   if (fetch && is_halt) state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      halted         <= 1'b0;
      pc             <= AW'(RESET_PC);
      IF_instruction <= '0;
      IF_pc          <= '0;
      IF_valid       <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == S_HALT);
      case (state)
        S_RUN: begin
          // Branch flushes IF even when stall is high; the halt word is dropped with it.
          if (br_taken) begin
            pc       <= br_target;
            IF_valid <= 1'b0;
          end else if (!stall) begin
            IF_instruction <= mem_rdata;
            IF_pc          <= pc;
            IF_valid       <= 1'b1;
            pc             <= pc + 1'b1;
          end
        end
        default: begin
          IF_valid <= 1'b0;
          if (start_ok) pc <= start_pc;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (fetch && perf_fetch != 16'hFFFF) perf_fetch <= perf_fetch + 16'd1;
      if (state == S_RUN && stall && !br_taken && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a cycle-level program-execution model pushes expected
// port values; a negedge monitor pops and compares them against the DUT.
module tb_imem_fetch_ctrl;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, start = 1'b0, stall = 1'b0, br_taken = 1'b0;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] start_pc = '0, br_target = '0, ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_gnt, mem_we, IF_valid, halted;
  logic [AW-1:0] mem_addr, IF_pc;
  logic [DW-1:0] mem_wdata, mem_rdata, IF_instruction;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   perf_fetch, perf_stall;
`endif

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .IF_instruction(IF_instruction), .IF_pc(IF_pc), .IF_valid(IF_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch(perf_fetch), .perf_stall(perf_stall),
`endif
    .halted(halted)
  );

  // Physical memory seen by the DUT
  logic [DW-1:0] mem [0:4095];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] ifpc;
    logic [DW-1:0] ins;
    logic [AW-1:0] addr;
    logic          hlt;
    logic          gnt;
    logic          we;
    logic [DW-1:0] wd;
    logic [15:0]   pf;
    logic [15:0]   ps;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  int            m_st = M_IDLE;
  logic [AW-1:0] m_pc, m_ifpc;
  logic [DW-1:0] m_ifi;
  logic          m_ifv;
  logic [DW-1:0] ref_mem [0:4095];
  int            m_pf, m_ps;
  bit            known = 0;

  initial for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("IF_valid", 32'(IF_valid), 32'(e.vld));
      chk("IF_pc", 32'(IF_pc), 32'(e.ifpc));
      chk("IF_instruction", 32'(IF_instruction), 32'(e.ins));
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("halted", 32'(halted), 32'(e.hlt));
      chk("ld_gnt", 32'(ld_gnt), 32'(e.gnt));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", 32'(perf_fetch), 32'(e.pf));
      chk("perf_stall", 32'(perf_stall), 32'(e.ps));
`endif
    end
  end

  task automatic step(input logic r, st, input logic [AW-1:0] spc, input logic sl, br,
                      input logic [AW-1:0] tgt, input logic lr, lw,
                      input logic [AW-1:0] la, input logic [DW-1:0] ld);
    exp_t e;
    @(posedge clk); #2;
    reset = r; start = st; start_pc = spc; stall = sl; br_taken = br; br_target = tgt;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_data = ld;
    if (known) begin
      e.vld  = m_ifv;
      e.ifpc = m_ifpc;
      e.ins  = m_ifi;
      e.gnt  = (m_st == M_LOAD);
      e.addr = e.gnt ? la : m_pc;
      e.hlt  = (m_st == M_HALT);
      e.we   = e.gnt && lw && !r;
      e.wd   = e.gnt ? ld : '0;
      e.pf   = 16'(m_pf);
      e.ps   = 16'(m_ps);
      q.push_back(e);
    end
    // Effect of the coming clock edge
    if (r) begin
      m_st = M_IDLE; m_pc = '0; m_ifv = 0; m_ifpc = '0; m_ifi = '0; m_pf = 0; m_ps = 0;
      known = 1;
    end else begin
      case (m_st)
        M_IDLE, M_HALT: begin
          m_ifv = 0;
          if (lr) m_st = M_LOAD;
          else if (st) begin m_st = M_RUN; m_pc = spc; m_pf = 0; m_ps = 0; end
        end
        M_LOAD: begin
          if (lw) ref_mem[la] = ld;
          if (!lr) m_st = M_IDLE;
        end
        default: begin
          if (br) begin
            m_pc = tgt; m_ifv = 0;
          end else if (sl) begin
            if (m_ps < 65535) m_ps++;
          end else begin
            m_ifi = ref_mem[m_pc]; m_ifpc = m_pc; m_ifv = 1; m_pc = m_pc + 1'b1;
            if (m_pf < 65535) m_pf++;
            if (m_ifi[15:12] == 4'hF) m_st = M_HALT;
          end
        end
      endcase
    end
  endtask

  task automatic rst();
    step(1, 0, '0, 0, 0, '0, 0, 0, '0, '0);
  endtask
  task automatic ld(input logic lr, lw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(0, 0, '0, 0, 0, '0, lr, lw, a, d);
  endtask
  task automatic go(input logic [AW-1:0] p);
    step(0, 1, p, 0, 0, '0, 0, 0, '0, '0);
  endtask
  task automatic run(input logic sl, br, input logic [AW-1:0] t);
    step(0, 0, '0, sl, br, t, 0, 0, '0, '0);
  endtask

  function automatic logic [DW-1:0] gen_word(input int a);
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    if (a >= 8 && a != 12'h100 && a != 12'h101 && $urandom_range(0, 31) == 0) op = 4'hF;
    return {op, 12'($urandom)};
  endfunction

  function automatic logic [AW-1:0] rnd_pc();
    return 12'($urandom_range(3, 12'h1FF));
  endfunction

  initial begin
    int n;
    rst(); rst();
    // Directed program load
    ld(1, 1, 12'd0, 16'h6181);
    ld(1, 1, 12'd1, 16'h6242);
    ld(1, 1, 12'd2, 16'hF000);
    ld(0, 0, '0, '0);
    run(0, 0, '0);
    // Random program fill with idle loader cycles interleaved
    for (int a = 3; a < 12'h200; a++) begin
      if ($urandom_range(0, 3) == 0) ld(1, 0, 12'($urandom), 16'($urandom));
      ld(1, 1, 12'(a), gen_word(a));
    end
    ld(1, 1, 12'hFFF, 16'h1234);
    ld(0, 1, 12'h7, 16'h0F0F);
    // Straight-line run to the halt word at address 2
    go(12'd0);
    repeat (6) run(0, 0, '0);
    // Stall three cycles at pc 5
    go(12'd3);
    run(0, 0, '0); run(0, 0, '0);
    repeat (3) run(1, 0, '0);
    run(0, 0, '0); run(0, 0, '0);
    // Branch overriding stall
    run(1, 1, 12'h100);
    run(0, 0, '0); run(0, 0, '0);
    rst();
    // PC wrap
    go(12'hFFF);
    repeat (6) run(0, 0, '0);
    // Loader requests during RUN wait until HALT
    rst();
    go(12'd3);
    n = 0;
    while (m_st == M_RUN && n < 5000) begin
      step(0, 0, '0, 0, 0, '0, 1, 1, 12'($urandom_range(12'h200, 12'h2FF)), 16'($urandom));
      n++;
    end
    chk("halt_reached", 32'(m_st == M_RUN), 32'd0);
    repeat (4) ld(1, 1, 12'($urandom_range(12'h200, 12'h2FF)), 16'($urandom));
    ld(0, 0, '0, '0);
    // Reset in the middle of a load burst
    ld(1, 0, '0, '0);
    ld(1, 1, 12'h300, 16'h1234);
    step(1, 0, '0, 0, 0, '0, 1, 1, 12'h301, 16'hABCD);
    run(0, 0, '0);
    go(12'h300);
    repeat (4) run(0, 0, '0);
    rst();
    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      go(rnd_pc());
      n = 0;
      while (m_st == M_RUN && n < 150) begin
        step(0, $urandom_range(0, 7) == 0, rnd_pc(), $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, rnd_pc(), 1'($urandom), 1'($urandom),
             12'($urandom), 16'($urandom));
        n++;
      end
      if (m_st == M_RUN || $urandom_range(0, 2) == 0) rst();
      else run(0, 0, '0);
    end
    run(0, 0, '0);
    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    chk("queue_drained", 32'(q.size()), 32'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
